// File: rtl/vco_phase_quantizer.sv
// Ring-VCO phase quantizer: synchronises the 32 phase taps, decodes the ring position
// and accumulates the modulo-64 phase advance per clock over DEC_LEN-clock windows.
module vco_phase_quantizer #(
    parameter int DEC_LEN = 16,
    parameter int OUT_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_qtz,
    input  logic [31:0]      out_vco_p,
    output logic [OUT_W-1:0] dout,
    output logic             dout_vld,
    output logic [5:0]       pos_q,
    output logic             bubble_err
);
    localparam int                CNT_W    = $clog2(DEC_LEN);
    localparam int                SUM_W    = OUT_W + 7;
    localparam logic [31:0]       ODD_MASK = 32'hAAAA_AAAA;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEC_LEN - 1);
    localparam logic [SUM_W-1:0]  ACC_MAX  = {7'd0, {OUT_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
    state_t state, next_state;

    logic [31:0]      s1, s2, t, t_edges;
    logic [5:0]       ones, trans, dec, pos_prev, d;
    logic             valid;
    logic [1:0]       prime_cnt;
    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] acc, acc_next;
    logic [SUM_W-1:0] sum;
    logic             win_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= out_vco_p;
            s2 <= s1;
        end
    end

    // Odd stages are inverting; flipping them yields a circular thermometer code.
    always_comb begin
        t       = s2 ^ ODD_MASK;
        t_edges = t ^ {t[0], t[31:1]};
        ones    = '0;
        trans   = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            ones  = ones + 6'(t[i]);
            trans = trans + 6'(t_edges[i]);
        end
        valid = (trans == 6'd0) || (trans == 6'd2);
        dec   = t[31] ? (6'd32 + (6'd32 - ones)) : ones;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q      <= '0;
            bubble_err <= 1'b0;
        end else begin
            if (valid)
                pos_q <= dec;
            if (!en_qtz)
                bubble_err <= 1'b0;
            else if (!valid)
                bubble_err <= 1'b1;
        end
    end

    // Plain 6-bit wrap gives the forward advance across the 63 -> 0 boundary.
    always_comb begin
        d        = pos_q - pos_prev;
        sum      = SUM_W'(acc) + SUM_W'(d);
        acc_next = (sum > ACC_MAX) ? '1 : sum[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        win_end    = 1'b0;
        case (state)
            IDLE:    if (en_qtz) next_state = PRIME;
            PRIME:   if (prime_cnt == 2'd2) next_state = RUN;
            RUN:     win_end = (cnt == CNT_LAST);
            default: next_state = IDLE;
        endcase
        if (!en_qtz)
            next_state = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt <= '0;
            cnt       <= '0;
            acc       <= '0;
            pos_prev  <= '0;
            dout      <= '0;
            dout_vld  <= 1'b0;
        end else if (!en_qtz) begin
            prime_cnt <= '0;
            cnt       <= '0;
            acc       <= '0;
            dout_vld  <= 1'b0;
        end else begin
            dout_vld <= 1'b0;
            case (state)
                IDLE: prime_cnt <= '0;
                PRIME: begin
                    // The last PRIME clock leaves pos_prev holding the window's reference position.
                    prime_cnt <= prime_cnt + 2'd1;
                    pos_prev  <= pos_q;
                    acc       <= '0;
                    cnt       <= '0;
                end
                RUN: begin
                    pos_prev <= pos_q;
                    if (win_end) begin
                        dout     <= acc_next;
                        dout_vld <= 1'b1;
                        acc      <= '0;
                        cnt      <= '0;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: prime_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_vco_phase_quantizer.sv
// Randomised bench for vco_phase_quantizer: a cycle-indexed history model predicts
// positions, bubble flag and window words for a 12-bit and a saturating 8-bit instance.
module tb_vco_phase_quantizer;
    localparam int          DEC  = 16;
    localparam int          NMAX = 8192;
    localparam logic [31:0] ODD  = 32'hAAAA_AAAA;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_qtz = 1'b0;
    logic [31:0] out_vco_p = ODD;
    logic [11:0] dout;
    logic        dout_vld;
    logic [5:0]  pos_q;
    logic        bubble_err;
    logic [7:0]  dout8;
    logic        vld8;
    logic [5:0]  pos8;
    logic        bub8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vco_phase_quantizer #(.DEC_LEN(DEC), .OUT_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .en_qtz(en_qtz), .out_vco_p(out_vco_p),
        .dout(dout), .dout_vld(dout_vld), .pos_q(pos_q), .bubble_err(bubble_err));

    vco_phase_quantizer #(.DEC_LEN(DEC), .OUT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en_qtz(en_qtz), .out_vco_p(out_vco_p),
        .dout(dout8), .dout_vld(vld8), .pos_q(pos8), .bubble_err(bub8));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Raw tap word an ideal ring shows at position p.
    function automatic logic [31:0] ring_taps(input int p);
        logic [31:0] th;
        if (p == 32)     th = '1;
        else if (p < 32) th = (32'd1 << p) - 32'd1;
        else             th = ~((32'd1 << (p - 32)) - 32'd1);
        return th ^ ODD;
    endfunction

    function automatic bit therm_ok(input logic [31:0] th);
        int n = 0;
        for (int i = 0; i < 32; i++)
            if (th[i] != th[(i + 1) % 32]) n++;
        return (n == 0) || (n == 2);
    endfunction

    function automatic int therm_pos(input logic [31:0] th);
        int c = $countones(th);
        return th[31] ? 32 + (32 - c) : c;
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] tp[NMAX];
    bit          en_h[NMAX];
    int          mpos[NMAX];
    bit          mbub[NMAX];
    int          k = 0;
    int          last_rst = 0;
    int          run_start = 0;
    int          mdout12 = 0;
    int          mdout8 = 0;
    bit          mvld = 0;

    initial forever begin
        @(negedge rst_n);
        last_rst = k;
        en_h[k]  = 1'b0;
        mpos[k]  = 0;
        mbub[k]  = 1'b0;
        mdout12  = 0;
        mdout8   = 0;
    end

    initial begin
        logic [31:0] th;
        bit ok;
        int n, sum;
        en_h[0] = 1'b0; mpos[0] = 0; mbub[0] = 1'b0;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                k++;
                if (k >= NMAX) begin
                    $display("FAIL model_overflow: got %0d expected below %0d", k, NMAX);
                    $fatal(1);
                end
                tp[k]   = out_vco_p;
                en_h[k] = en_qtz;
                th      = (k - 2 <= last_rst) ? ODD : (tp[k - 2] ^ ODD);
                ok      = therm_ok(th);
                mpos[k] = ok ? therm_pos(th) : mpos[k - 1];
                mbub[k] = en_h[k] && (mbub[k - 1] || !ok);
                if (en_h[k] && !en_h[k - 1]) run_start = k;
                mvld = 1'b0;
                if (en_h[k]) begin
                    n = k - run_start;
                    if (n >= 3 + DEC && ((n - 3 - DEC) % DEC) == 0) begin
                        sum = 0;
                        for (int j = k - DEC + 1; j <= k; j++)
                            sum += (mpos[j - 1] - mpos[j - 2]) & 63;
                        mvld    = 1'b1;
                        mdout12 = (sum > 4095) ? 4095 : sum;
                        mdout8  = (sum > 255) ? 255 : sum;
                    end
                end
                #1;
                chk("pos_q",      pos_q,      mpos[k]);
                chk("pos_q8",     pos8,       mpos[k]);
                chk("bubble_err", bubble_err, mbub[k]);
                chk("bubble8",    bub8,       mbub[k]);
                chk("dout_vld",   dout_vld,   mvld);
                chk("vld8",       vld8,       mvld);
                chk("dout",       dout,       mdout12);
                chk("dout8",      dout8,      mdout8);
            end
        end
    end

    // ---------------- ring stimulus ----------------
    int ring = 0;
    int stride = 0;
    bit rand_mode = 0;
    bit inject = 0;

    initial forever begin
        @(negedge clk);
        if (rand_mode) stride = $urandom_range(0, 63);
        ring = (ring + stride) % 64;
        out_vco_p = ring_taps(ring);
        if (inject)
            out_vco_p = 32'h0000_0505 ^ ODD;
        else if (rand_mode && $urandom_range(0, 15) == 0)
            out_vco_p = $urandom();
        inject = 0;
    end

    task automatic wait_vld(input string name, output int n);
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (dout_vld) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout: got no dout_vld within %0d clks", name, n);
                break;
            end
        end
    endtask

    initial begin
        int n;
        int p0;
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_vld", dout_vld, 0);
        chk("rst_pos", pos_q, 0);
        chk("rst_bub", bubble_err, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // frozen at position 0
        en_qtz = 1'b1;
        wait_vld("t1", n);
        chk("t1_latency", n, 3 + DEC);
        chk("t1_dout", dout, 0);
        chk("t1_bub", bubble_err, 0);
        wait_vld("t1b", n);
        chk("t1_period", n, DEC - 1);

        // ideal ring, +4 per clock
        stride = 4;
        wait_vld("t2a", n);
        wait_vld("t2b", n);
        wait_vld("t2c", n);
        chk("t2_dout", dout, 64);
        p0 = pos_q;
        @(posedge clk); #1;
        chk("t2_step", (pos_q - p0) & 63, 4);

        // +3 per clock, wraps through 63 -> 0 inside and across windows
        stride = 3;
        wait_vld("t3a", n);
        wait_vld("t3b", n);
        wait_vld("t3c", n);
        chk("t3_dout", dout, 48);

        // single bubble pattern mid-window
        repeat (5) @(negedge clk);
        inject = 1;
        repeat (4) @(negedge clk);
        chk("t4_bub_set", bubble_err, 1);
        wait_vld("t4", n);
        @(negedge clk);
        en_qtz = 1'b0;
        @(posedge clk); #1;
        chk("t4_bub_clr", bubble_err, 0);
        chk("t4_vld_low", dout_vld, 0);
        @(negedge clk);
        en_qtz = 1'b1;

        // +63 per clock saturates the 8-bit instance
        stride = 63;
        wait_vld("t5a", n);
        wait_vld("t5b", n);
        wait_vld("t5c", n);
        chk("t5_dout8", dout8, 255);
        chk("t5_dout12", dout, 63 * DEC);

        // enable drop mid-window: no partial word, full restart latency
        stride = 5;
        repeat (6) @(negedge clk);
        en_qtz = 1'b0;
        @(negedge clk);
        en_qtz = 1'b1;
        wait_vld("t6a", n);
        chk("t6_drop_latency", n, 3 + DEC);

        // async reset mid-window
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_pos", pos_q, 0);
        chk("t6_rst_dout", dout, 0);
        chk("t6_rst_vld", dout_vld, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_vld("t6b", n);
        chk("t6_rst_latency", n, 3 + DEC);

        // random strides, random raw tap words and enable glitches
        rand_mode = 1;
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(40, 120)) @(negedge clk);
            en_qtz = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            en_qtz = 1'b1;
        end
        repeat (200) @(negedge clk);
        rand_mode = 0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
